// File: rtl/vga_sync_generator.sv
// vga_sync_generator
//
// Raster timing generator for the image pixel controller. It walks a
// horizontal/vertical counter pair across the full frame (active area plus
// porches and sync) and drives hsync/vsync, the video_on blanking qualifier,
// line/frame markers and a free-running completed-frame counter.
// The defaults give 640x480 at 60 Hz from a 25 MHz pixel clock.
//
// Ports
//   clk          pixel clock, the only clock
//   reset        synchronous, active-high; takes priority over pix_en
//   pix_en       advance strobe; the raster moves one pixel per enabled edge
//   hsync        horizontal sync, asserted level = SYNC_POL
//   vsync        vertical sync, asserted level = SYNC_POL
//   video_on     high while (curr_x, curr_y) lies in the visible area
//   curr_x       horizontal position, 0..H_TOTAL-1
//   curr_y       vertical position, 0..V_TOTAL-1
//   line_start   high while curr_x == 0
//   frame_start  high while curr_x == 0 and curr_y == 0
//   frame_count  completed frames, wraps 255 -> 0
//
// Handshake: there is no valid/ready pair. pix_en is a plain qualifier; an
// edge with pix_en=1 advances the raster by one position, an edge with
// pix_en=0 leaves every output unchanged.
//
// Every output is a register loaded from the *next* counter values, so the
// flags are always aligned with the curr_x/curr_y pair being presented.

module vga_sync_generator #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] curr_x,
    output logic [9:0] curr_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters are 10 bits wide, so neither total may exceed 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_sync_generator: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    // Boundaries held at 11 bits so a total of exactly 1024 still compares
    // correctly against the zero-extended 10-bit counters.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic [7:0] fc_next;
    logic [10:0] x_next_ext;
    logic [10:0] y_next_ext;
    logic       hsync_next;
    logic       vsync_next;
    logic       video_on_next;
    logic       line_start_next;
    logic       frame_start_next;

    // Next raster position and the flags derived from it.
    always_comb begin
        x_wrap  = ({1'b0, curr_x} == H_LAST);
        y_wrap  = ({1'b0, curr_y} == V_LAST);
        x_next  = x_wrap ? 10'd0 : curr_x + 10'd1;
        y_next  = curr_y;
        fc_next = frame_count;

        // The vertical counter only moves on the line wrap; the frame
        // counter only moves when both counters wrap together.
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : curr_y + 10'd1;
            if (y_wrap) begin
                fc_next = frame_count + 8'd1;
            end
        end

        x_next_ext = {1'b0, x_next};
        y_next_ext = {1'b0, y_next};

        hsync_next = ((x_next_ext >= H_SYNC_BEG) && (x_next_ext < H_SYNC_END))
                     ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((y_next_ext >= V_SYNC_BEG) && (y_next_ext < V_SYNC_END))
                     ? SYNC_POL : ~SYNC_POL;
        video_on_next    = (x_next_ext < H_VIS) && (y_next_ext < V_VIS);
        line_start_next  = (x_next == 10'd0);
        frame_start_next = (x_next == 10'd0) && (y_next == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curr_x      <= 10'd0;
            curr_y      <= 10'd0;
            frame_count <= 8'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (pix_en) begin
            curr_x      <= x_next;
            curr_y      <= y_next;
            frame_count <= fc_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            video_on    <= video_on_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator
//
// Three instances share one clock:
//   u0 : default 640x480 timing, SYNC_POL=0
//   u1 : short lines (8/1/2/1) with the default vertical timing
//   u2 : short lines and short frames (8/1/2/1, 4/1/1/1), SYNC_POL=1
// A behavioural raster model per instance feeds an expected-value queue on
// every clock edge; the queue is drained and compared just after the edge.
// Directed checks on top of that measure pulse positions, widths and
// periods against fixed numbers.

module tb_vga_sync_generator;

    localparam int HA  [3] = '{640, 8, 8};
    localparam int HF  [3] = '{16, 1, 1};
    localparam int HSW [3] = '{96, 2, 2};
    localparam int HB  [3] = '{48, 1, 1};
    localparam int VA  [3] = '{480, 480, 4};
    localparam int VF  [3] = '{10, 10, 1};
    localparam int VSW [3] = '{2, 2, 1};
    localparam int VB  [3] = '{33, 33, 1};
    localparam int POL [3] = '{0, 0, 1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] en;

    logic [2:0] hs_w, vs_w, von_w, ls_w, fs_w;
    logic [9:0] x_w  [3];
    logic [9:0] y_w  [3];
    logic [7:0] fc_w [3];

    vga_sync_generator u0 (
        .clk(clk), .reset(rst[0]), .pix_en(en[0]),
        .hsync(hs_w[0]), .vsync(vs_w[0]), .video_on(von_w[0]),
        .curr_x(x_w[0]), .curr_y(y_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]), .frame_count(fc_w[0])
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) u1 (
        .clk(clk), .reset(rst[1]), .pix_en(en[1]),
        .hsync(hs_w[1]), .vsync(vs_w[1]), .video_on(von_w[1]),
        .curr_x(x_w[1]), .curr_y(y_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]), .frame_count(fc_w[1])
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u2 (
        .clk(clk), .reset(rst[2]), .pix_en(en[2]),
        .hsync(hs_w[2]), .vsync(vs_w[2]), .video_on(von_w[2]),
        .curr_x(x_w[2]), .curr_y(y_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]), .frame_count(fc_w[2])
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    int mx  [3];
    int my  [3];
    int mfc [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] exp_vec(int i);
        int   hb  = HA[i] + HF[i];
        int   vb  = VA[i] + VF[i];
        logic pol = (POL[i] != 0);
        logic hs, vs, von, ls, fs;
        hs  = (mx[i] >= hb && mx[i] < hb + HSW[i]) ? pol : !pol;
        vs  = (my[i] >= vb && my[i] < vb + VSW[i]) ? pol : !pol;
        von = (mx[i] < HA[i]) && (my[i] < VA[i]);
        ls  = (mx[i] == 0);
        fs  = (mx[i] == 0) && (my[i] == 0);
        return {hs, vs, von, ls, fs, 10'(mx[i]), 10'(my[i]), 8'(mfc[i])};
    endfunction

    function automatic logic [32:0] obs_vec(int i);
        return {hs_w[i], vs_w[i], von_w[i], ls_w[i], fs_w[i], x_w[i], y_w[i], fc_w[i]};
    endfunction

    task automatic model_update(int i);
        int ht = HA[i] + HF[i] + HSW[i] + HB[i];
        int vt = VA[i] + VF[i] + VSW[i] + VB[i];
        if (rst[i]) begin
            mx[i] = 0; my[i] = 0; mfc[i] = 0;
        end else if (en[i]) begin
            if (mx[i] == ht - 1) begin
                mx[i] = 0;
                if (my[i] == vt - 1) begin
                    my[i]  = 0;
                    mfc[i] = (mfc[i] + 1) % 256;
                end else begin
                    my[i] = my[i] + 1;
                end
            end else begin
                mx[i] = mx[i] + 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock edge: model advances on the edge, expectations are queued,
    // outputs are sampled 1 time unit later and compared.
    task automatic step();
        logic [32:0] e;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_update(i);
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_vec(i));
        #1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            check($sformatf("sb_u%0d", i), {31'd0, obs_vec(i)}, {31'd0, e});
        end
    endtask

    // ---------------- directed sequence ----------------
    int hs_low, first_low, last_low, first_blank;
    int bad_runs, skips, changes, prev_x, run_len, first_run;
    int vs_low, vs_min, vs_max, von_bad, von_blank;
    int hs_hi, vs_hi, hs_hi_out, vs_hi_out;

    initial begin
        rst = 3'b111;
        en  = 3'b000;
        step();
        step();

        // Reset values, default instance
        check("rst_x",   x_w[0], 0);
        check("rst_y",   y_w[0], 0);
        check("rst_von", von_w[0], 1);
        check("rst_hs",  hs_w[0], 1);
        check("rst_vs",  vs_w[0], 1);
        check("rst_fc",  fc_w[0], 0);
        check("rst_fs",  fs_w[0], 1);
        check("rst_ls",  ls_w[0], 1);

        // Horizontal timing over line 0
        rst = 3'b000;
        en  = 3'b111;
        hs_low = 0; first_low = -1; last_low = -1; first_blank = -1;
        for (int i = 0; i < 799; i++) begin
            step();
            if (hs_w[0] == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(x_w[0]);
                last_low = int'(x_w[0]);
            end
            if (von_w[0] == 1'b0 && first_blank < 0) first_blank = int'(x_w[0]);
        end
        check("h_blank_x",   first_blank, 640);
        check("h_sync_w",    hs_low, 96);
        check("h_sync_beg",  first_low, 656);
        check("h_sync_end",  last_low, 751);
        check("h_last_x",    x_w[0], 799);
        check("h_last_ls",   ls_w[0], 0);
        step();
        check("h_wrap_x",    x_w[0], 0);
        check("h_wrap_y",    y_w[0], 1);
        check("h_wrap_ls",   ls_w[0], 1);
        step();
        check("h_after_ls",  ls_w[0], 0);
        check("h_after_x",   x_w[0], 1);

        // Reset in the middle of a line
        for (int i = 0; i < 299; i++) step();
        check("mid_x", x_w[0], 300);
        check("mid_y", y_w[0], 1);
        rst[0] = 1'b1;
        step();
        check("mrst_x",   x_w[0], 0);
        check("mrst_y",   y_w[0], 0);
        check("mrst_von", von_w[0], 1);
        check("mrst_hs",  hs_w[0], 1);
        check("mrst_vs",  vs_w[0], 1);
        check("mrst_fc",  fc_w[0], 0);
        check("mrst_fs",  fs_w[0], 1);
        step();
        step();
        rst[0] = 1'b0;

        // Enable gating: one enabled edge in four on u0
        hs_low = 0; bad_runs = 0; skips = 0; changes = 0;
        prev_x = int'(x_w[0]); run_len = 0; first_run = 1;
        for (int i = 0; i < 3200; i++) begin
            en[0] = (i % 4 == 0);
            step();
            if (hs_w[0] == 1'b0) hs_low++;
            if (int'(x_w[0]) == prev_x) begin
                run_len++;
            end else begin
                if (first_run == 0 && run_len != 4) bad_runs++;
                if (int'(x_w[0]) != ((prev_x == 799) ? 0 : prev_x + 1)) skips++;
                changes++;
                first_run = 0;
                run_len = 1;
                prev_x = int'(x_w[0]);
            end
        end
        en[0] = 1'b1;
        check("gate_hs_w",     hs_low, 384);
        check("gate_runs",     bad_runs, 0);
        check("gate_skips",    skips, 0);
        check("gate_changes",  changes, 800);
        check("gate_line_x",   x_w[0], 0);
        check("gate_line_y",   y_w[0], 1);

        // Vertical timing over a full frame on u1
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        vs_low = 0; vs_min = 9999; vs_max = -1; von_bad = 0; von_blank = 0;
        for (int i = 0; i < 6300; i++) begin
            step();
            if (vs_w[1] == 1'b0) begin
                vs_low++;
                if (int'(y_w[1]) < vs_min) vs_min = int'(y_w[1]);
                if (int'(y_w[1]) > vs_max) vs_max = int'(y_w[1]);
            end
            if (y_w[1] >= 10'd480) begin
                if (von_w[1] == 1'b1) von_bad++;
                else von_blank++;
            end
        end
        check("v_sync_w",    vs_low, 24);
        check("v_sync_beg",  vs_min, 490);
        check("v_sync_end",  vs_max, 491);
        check("v_von_bad",   von_bad, 0);
        check("v_von_blank", von_blank, 540);
        check("v_wrap_x",    x_w[1], 0);
        check("v_wrap_y",    y_w[1], 0);
        check("v_wrap_fs",   fs_w[1], 1);
        check("v_wrap_fc",   fc_w[1], 1);

        // Positive sync polarity and frame counter wrap on u2
        rst[2] = 1'b1;
        step();
        check("pol_rst_hs", hs_w[2], 0);
        check("pol_rst_vs", vs_w[2], 0);
        rst[2] = 1'b0;
        hs_hi = 0; vs_hi = 0; hs_hi_out = 0; vs_hi_out = 0;
        for (int i = 0; i < 84; i++) begin
            step();
            if (hs_w[2] == 1'b1) begin
                hs_hi++;
                if (x_w[2] < 10'd9 || x_w[2] > 10'd10) hs_hi_out++;
            end
            if (vs_w[2] == 1'b1) begin
                vs_hi++;
                if (y_w[2] != 10'd5) vs_hi_out++;
            end
        end
        check("pol_hs_hi",     hs_hi, 14);
        check("pol_vs_hi",     vs_hi, 12);
        check("pol_hs_out",    hs_hi_out, 0);
        check("pol_vs_out",    vs_hi_out, 0);
        check("pol_fc1",       fc_w[2], 1);
        for (int i = 0; i < 254 * 84; i++) step();
        check("fc_255",        fc_w[2], 255);
        for (int i = 0; i < 84; i++) step();
        check("fc_wrap",       fc_w[2], 0);
        check("fc_wrap_x",     x_w[2], 0);
        check("fc_wrap_y",     y_w[2], 0);
        check("fc_wrap_fs",    fs_w[2], 1);

        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
